// File: rtl/lz4_frame_tail_pkg.sv
// Shared LZ4 frame definitions: tail FSM state encoding, EndMark word and the
// byte-swap helper used to put the xxh32 digest into stream byte order.
package lz4_frame_tail_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PASS     = 3'd1;
  localparam logic [2:0] ST_END_MARK = 3'd2;
  localparam logic [2:0] ST_WAIT_DIG = 3'd3;
  localparam logic [2:0] ST_CKSUM    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    PASS     = ST_PASS,
    END_MARK = ST_END_MARK,
    WAIT_DIG = ST_WAIT_DIG,
    CKSUM    = ST_CKSUM,
    DONE     = ST_DONE
  } state_t;

  localparam logic [31:0] END_MARK_WORD = 32'h0000_0000;

  // The digest is little-endian on the wire, the stream word is big-endian.
  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/lz4_frame_tail.sv
// LZ4 frame tail: forwards compressed block words, then appends the EndMark
// and (optionally) the content checksum through a single output register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no frame open; only digest capture is active
// PASS     | compressed block words forwarded one cycle after acceptance
// END_MARK | waiting to load the 32'h0 EndMark word
// WAIT_DIG | EndMark loaded, no digest held yet
// CKSUM    | waiting to load the byte-swapped digest word
// DONE     | waiting for the final word to leave, then pulse tail_done
module lz4_frame_tail
  import lz4_frame_tail_pkg::*;
#(
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        compress_start,
  input  logic [31:0] blk_data,
  input  logic        blk_valid,
  input  logic        blk_last,
  output logic        blk_ready,
  input  logic [31:0] digest,
  input  logic        digest_valid,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        tail_done,
  output logic [31:0] frame_words
);

  state_t      state;
  logic        have_digest;
  logic [31:0] digest_q;
  logic        xfer;
  logic        load_en;

  assign xfer      = out_valid && out_ready;
  assign load_en   = !out_valid || out_ready;
  assign blk_ready = (state == PASS) && load_en;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      tail_done   <= 1'b0;
      frame_words <= '0;
      have_digest <= 1'b0;
      digest_q    <= '0;
    end else begin
      tail_done <= 1'b0;
      if (xfer) begin
        frame_words <= frame_words + 32'd1;
        out_valid   <= 1'b0;
      end

      if (compress_start) begin
        // A start outside IDLE aborts the open frame without a tail_done.
        state       <= PASS;
        out_valid   <= 1'b0;
        out_last    <= 1'b0;
        frame_words <= '0;
        if (state != IDLE) have_digest <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          PASS: begin
            if (blk_valid && blk_ready) begin
              out_data  <= blk_data;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              if (blk_last) state <= END_MARK;
            end
          end
          END_MARK: begin
            if (load_en) begin
              out_data  <= END_MARK_WORD;
              out_valid <= 1'b1;
              out_last  <= !CHECKSUM_EN;
              if (!CHECKSUM_EN)    state <= DONE;
              else if (have_digest) state <= CKSUM;
              else                  state <= WAIT_DIG;
            end
          end
          WAIT_DIG: begin
            if (have_digest || digest_valid) state <= CKSUM;
          end
          CKSUM: begin
            if (load_en) begin
              out_data  <= byte_swap(digest_q);
              out_valid <= 1'b1;
              out_last  <= 1'b1;
              state     <= DONE;
            end
          end
          DONE: begin
            if (xfer && out_last) begin
              tail_done   <= 1'b1;
              have_digest <= 1'b0;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Placed after the start handling so a same-cycle digest lands in the new frame.
      if (digest_valid && (compress_start || (state != DONE && !have_digest))) begin
        digest_q    <= digest;
        have_digest <= 1'b1;
      end
    end
  end

endmodule

// File: doc/lz4_frame_tail.md
LZ4_FRAME_TAIL -- requirements
Module: lz4_frame_tail

Interface
REQ-001 SHALL have parameter CHECKSUM_EN, default 1; when 1, the content checksum word is appended after the EndMark.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rstN, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port compress_start, input, 1 bit: one-cycle pulse that opens a new frame.
REQ-005 SHALL have port blk_data, input, 32 bits: compressed block word; first stream byte is in [31:24].
REQ-006 SHALL have port blk_valid, input, 1 bit: blk_data is valid.
REQ-007 SHALL have port blk_last, input, 1 bit: marks the final compressed word; qualified by blk_valid.
REQ-008 SHALL have port blk_ready, output, 1 bit: the block accepts blk_data.
REQ-009 SHALL have port digest, input, 32 bits: xxh32 result from the hash stage.
REQ-010 SHALL have port digest_valid, input, 1 bit: one-cycle pulse qualifying digest.
REQ-011 SHALL have port out_data, output, 32 bits: frame stream word.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the sink accepts out_data.
REQ-014 SHALL have port out_last, output, 1 bit: marks the final frame word.
REQ-015 SHALL have port tail_done, output, 1 bit: one-cycle pulse after the final word transfers.
REQ-016 SHALL have port frame_words, output, 32 bits: count of words transferred in the current frame.

Function
REQ-017 SHALL implement FSM states IDLE, PASS, END_MARK, WAIT_DIG, CKSUM, DONE.
REQ-018 SHALL transition IDLE->PASS on compress_start; all other inputs are ignored in IDLE except digest capture (REQ-025).
REQ-019 SHALL use a single output register; a transfer occurs when out_valid && out_ready; the register loads when !out_valid || out_ready.
REQ-020 In PASS, SHALL drive blk_ready = !out_valid || out_ready; each accepted word appears on out_data exactly one cycle later, unmodified, with out_last=0.
REQ-021 SHALL transition PASS->END_MARK when a word with blk_last=1 is accepted; blk_ready=0 in all states except PASS.
REQ-022 In END_MARK, SHALL load 32'h0000_0000; out_last = !CHECKSUM_EN.
REQ-023 After the EndMark loads, SHALL go to CKSUM if a digest is held, to WAIT_DIG if none is held, or to DONE if CHECKSUM_EN=0.
REQ-024 In CKSUM, SHALL load the byte-swapped digest {d[7:0],d[15:8],d[23:16],d[31:24]} with out_last=1, then go to DONE.
REQ-025 SHALL capture digest on digest_valid in any state except DONE and set a have_digest flag; the first capture in a frame is held and later pulses are ignored; WAIT_DIG->CKSUM occurs on the cycle after the capture.
REQ-026 In DONE, SHALL wait for the out_last word to transfer, then pulse tail_done for one cycle, clear have_digest, and go to IDLE.
REQ-027 SHALL increment frame_words by 1 on every transfer, clear it on compress_start, and hold it in IDLE; it wraps modulo 2^32.
REQ-028 If compress_start occurs in a non-IDLE state, SHALL abort the frame: drop out_valid, clear have_digest and frame_words, and enter PASS; no tail_done is produced for the aborted frame.
REQ-029 If digest_valid and compress_start occur in the same cycle, SHALL apply the start first, then capture the digest into the new frame.
REQ-030 A blk_last word accepted in the same cycle as a digest capture SHALL produce the EndMark first, then the checksum, with no idle cycle between them when out_ready=1.
REQ-031 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.

Reset
REQ-032 While rstN=0, SHALL force state=IDLE, out_valid=0, out_data=0, out_last=0, blk_ready=0, tail_done=0, frame_words=0, have_digest=0, and clear the held digest.
REQ-033 SHALL begin operating on the first clk edge after rstN deasserts.

Structure
REQ-034 SHALL place the FSM state encoding (3-bit localparams) and the END_MARK constant 32'h0000_0000 in the shared LZ4 package.
REQ-035 SHALL be flat; no sub-module is required, and the byte swap is a shared package function.

Verification
REQ-036 Test 1: start; three words A1B2C3D4, 11223344, 55667788 with the last flagged; digest 02CC5D05 pulsed afterwards; out_ready=1 -> output A1B2C3D4, 11223344, 55667788, 00000000, 055DCC02 with last on the final word; tail_done pulses once; frame_words=5.
REQ-037 Test 2: digest 12345678 pulsed before the first word -> checksum word 78563412 immediately follows the EndMark with no gap.
REQ-038 Test 3: out_ready toggles 1,0,0,1 per cycle during the stream -> no word is lost or duplicated, and out_data is stable while stalled.
REQ-039 Test 4: CHECKSUM_EN=0; one word DEADBEEF with last -> output DEADBEEF, 00000000 with last on the EndMark; frame_words=2.
REQ-040 Test 5: compress_start after the second of four words -> out_valid drops, frame_words=0, the new frame completes normally, and exactly one tail_done pulse occurs.
REQ-041 Test 6: rstN pulled low mid-CKSUM while out_ready=0 -> all outputs are 0 immediately; the next frame completes correctly.
